// File: rtl/m92_pkg.sv
// rtl/m92_pkg.sv - shared types and helpers for the M92 SDRAM CPU port
// Purpose: state encoding, default line geometry and tag extraction used by
//          m92_sdr_cpu_port and m92_line_cache.
// Ports:   none (package).
package m92_pkg;

    localparam int SDR_CPU_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        SDR_IDLE,
        SDR_HIT,
        SDR_RD_REQ,
        SDR_RD_FILL,
        SDR_WR_REQ
    } sdr_cpu_state_t;

    // Tag of a byte address: everything above the word index and the byte bit.
    function automatic logic [24:0] line_tag(input logic [24:0] addr, input int wbits);
        return addr >> (wbits + 1);
    endfunction

endpackage

// File: rtl/m92_line_cache.sv
// rtl/m92_line_cache.sv - single-line read cache storage for the CPU SDRAM port
// Purpose: LINE_WORDS x 16 data array with one tag and a valid bit.
// Ports:   clk, reset        - clock, synchronous active-high reset (valid only)
//          inval             - clear valid (highest priority)
//          tag_we, tag_in    - store line tag; set_valid marks the line valid
//          fill_we/idx/data  - burst fill write port
//          wr_we/idx/be/data - byte-enable write port (CPU write merge)
//          rd_tag, rd_idx    - combinational lookup; hit and rd_data out
module m92_line_cache
    import m92_pkg::*;
#(
    parameter int LINE_WORDS = SDR_CPU_LINE_WORDS,
    localparam int WBITS     = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inval,
    input  logic             tag_we,
    input  logic [24:0]      tag_in,
    input  logic             set_valid,
    input  logic             fill_we,
    input  logic [WBITS-1:0] fill_idx,
    input  logic [15:0]      fill_data,
    input  logic             wr_we,
    input  logic [WBITS-1:0] wr_idx,
    input  logic [1:0]       wr_be,
    input  logic [15:0]      wr_data,
    input  logic [24:0]      rd_tag,
    input  logic [WBITS-1:0] rd_idx,
    output logic             hit,
    output logic [15:0]      rd_data
);

    logic [15:0] data [LINE_WORDS];
    logic [24:0] tag;
    logic        valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
        end else begin
            if (tag_we) begin
                tag <= tag_in;
            end
            // Invalidation beats validation so a flush in the last fill cycle sticks.
            if (inval) begin
                valid <= 1'b0;
            end else if (set_valid) begin
                valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[fill_idx] <= fill_data;
        end else if (wr_we) begin
            if (wr_be[0]) data[wr_idx][7:0]  <= wr_data[7:0];
            if (wr_be[1]) data[wr_idx][15:8] <= wr_data[15:8];
        end
    end

    assign hit     = valid && (tag == rd_tag);
    assign rd_data = data[rd_idx];

endmodule

// File: rtl/m92_sdr_cpu_port.sv
// rtl/m92_sdr_cpu_port.sv - main-CPU SDRAM channel responder with one-line read cache
// Purpose: accepts single-cycle CPU request pulses, serves reads from a one-line
//          cache or an SDRAM burst (critical word returned early), writes through
//          to SDRAM, and answers every request with a single-cycle cpu_rdy pulse.
// Ports:   clk, reset                          - 96 MHz clock, sync active-high reset
//          cpu_addr/din/wr_sel/req             - CPU request (wr_sel 00 = read)
//          cpu_dout, cpu_rdy                   - CPU response
//          flush                               - invalidate the cache line
//          sdr_addr/wr/be/din/req, sdr_ack     - SDRAM command handshake
//          sdr_dout, sdr_dout_valid            - SDRAM burst read data
module m92_sdr_cpu_port
    import m92_pkg::*;
#(
    parameter int LINE_WORDS = SDR_CPU_LINE_WORDS,
    parameter bit CACHE_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [24:0] cpu_addr,
    input  logic [15:0] cpu_din,
    input  logic [1:0]  cpu_wr_sel,
    input  logic        cpu_req,
    output logic [15:0] cpu_dout,
    output logic        cpu_rdy,
    input  logic        flush,
    output logic [24:0] sdr_addr,
    output logic        sdr_wr,
    output logic [1:0]  sdr_be,
    output logic [15:0] sdr_din,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_dout,
    input  logic        sdr_dout_valid
);

    localparam int               WBITS     = $clog2(LINE_WORDS);
    localparam logic [24:0]      LINE_MASK = ~25'((1 << (WBITS + 1)) - 1);
    localparam logic [WBITS-1:0] LAST_IDX  = WBITS'(LINE_WORDS - 1);

    sdr_cpu_state_t state, state_n;

    logic [15:0]      cpu_dout_n;
    logic             cpu_rdy_n;
    logic [24:0]      sdr_addr_n;
    logic             sdr_wr_n;
    logic [1:0]       sdr_be_n;
    logic [15:0]      sdr_din_n;
    logic             sdr_req_n;

    logic [24:0]      cur_addr, cur_addr_n;
    logic [15:0]      cur_din, cur_din_n;
    logic [1:0]       cur_sel, cur_sel_n;
    logic             pend_valid, pend_valid_n;
    logic [24:0]      pend_addr, pend_addr_n;
    logic [15:0]      pend_din, pend_din_n;
    logic [1:0]       pend_sel, pend_sel_n;
    logic [WBITS-1:0] fill_cnt, fill_cnt_n;
    logic             fill_flushed, fill_flushed_n;
    logic             ovf_err, ovf_err_n;

    logic             take_pend;
    logic [24:0]      req_addr;
    logic [15:0]      req_din;
    logic [1:0]       req_sel;
    logic [24:0]      look_addr;

    logic             c_inval, c_tag_we, c_set_valid, c_fill_we, c_wr_we;
    logic             c_hit;
    logic [15:0]      c_rd_data;

    m92_line_cache #(
        .LINE_WORDS (LINE_WORDS)
    ) u_cache (
        .clk       (clk),
        .reset     (reset),
        .inval     (c_inval),
        .tag_we    (c_tag_we),
        .tag_in    (line_tag(cur_addr, WBITS)),
        .set_valid (c_set_valid),
        .fill_we   (c_fill_we),
        .fill_idx  (fill_cnt),
        .fill_data (sdr_dout),
        .wr_we     (c_wr_we),
        .wr_idx    (cur_addr[WBITS:1]),
        .wr_be     (cur_sel),
        .wr_data   (cur_din),
        .rd_tag    (line_tag(look_addr, WBITS)),
        .rd_idx    (look_addr[WBITS:1]),
        .hit       (c_hit),
        .rd_data   (c_rd_data)
    );

    // A parked request always goes first; a fresh pulse in that cycle refills the slot.
    assign take_pend = (state == SDR_IDLE) && pend_valid;
    assign req_addr  = take_pend ? pend_addr : cpu_addr;
    assign req_din   = take_pend ? pend_din  : cpu_din;
    assign req_sel   = take_pend ? pend_sel  : cpu_wr_sel;
    // Lookup the incoming request when idle, otherwise the one in flight (write merge).
    assign look_addr = (state == SDR_IDLE) ? req_addr : cur_addr;

    always_comb begin
        state_n        = state;
        cpu_rdy_n      = 1'b0;
        cpu_dout_n     = cpu_dout;
        sdr_addr_n     = sdr_addr;
        sdr_wr_n       = sdr_wr;
        sdr_be_n       = sdr_be;
        sdr_din_n      = sdr_din;
        sdr_req_n      = sdr_req;
        cur_addr_n     = cur_addr;
        cur_din_n      = cur_din;
        cur_sel_n      = cur_sel;
        pend_valid_n   = pend_valid;
        pend_addr_n    = pend_addr;
        pend_din_n     = pend_din;
        pend_sel_n     = pend_sel;
        fill_cnt_n     = fill_cnt;
        fill_flushed_n = fill_flushed | flush;
        ovf_err_n      = ovf_err;
        c_inval        = flush;
        c_tag_we       = 1'b0;
        c_set_valid    = 1'b0;
        c_fill_we      = 1'b0;
        c_wr_we        = 1'b0;

        // Pending slot bookkeeping.
        if (take_pend) begin
            pend_valid_n = cpu_req;
        end
        if (cpu_req && (take_pend || state != SDR_IDLE)) begin
            if (take_pend || !pend_valid) begin
                pend_valid_n = 1'b1;
                pend_addr_n  = cpu_addr;
                pend_din_n   = cpu_din;
                pend_sel_n   = cpu_wr_sel;
            end else begin
                ovf_err_n = 1'b1;
            end
        end

        unique case (state)
            SDR_IDLE: begin
                if (take_pend || cpu_req) begin
                    cur_addr_n = req_addr;
                    cur_din_n  = req_din;
                    cur_sel_n  = req_sel;
                    if (req_sel != 2'b00) begin
                        state_n    = SDR_WR_REQ;
                        sdr_req_n  = 1'b1;
                        sdr_wr_n   = 1'b1;
                        sdr_be_n   = req_sel;
                        sdr_din_n  = req_din;
                        sdr_addr_n = {req_addr[24:1], 1'b0};
                    end else if (CACHE_EN && c_hit && !flush) begin
                        state_n    = SDR_HIT;
                        cpu_rdy_n  = 1'b1;
                        cpu_dout_n = c_rd_data;
                    end else begin
                        state_n        = SDR_RD_REQ;
                        sdr_req_n      = 1'b1;
                        sdr_wr_n       = 1'b0;
                        sdr_addr_n     = req_addr & LINE_MASK;
                        c_inval        = 1'b1;
                        fill_cnt_n     = '0;
                        fill_flushed_n = 1'b0;
                    end
                end
            end
            SDR_HIT: begin
                state_n = SDR_IDLE;
            end
            SDR_RD_REQ: begin
                if (sdr_ack) begin
                    sdr_req_n = 1'b0;
                    state_n   = SDR_RD_FILL;
                end
            end
            SDR_RD_FILL: begin
                if (sdr_dout_valid) begin
                    c_fill_we = 1'b1;
                    if (fill_cnt == cur_addr[WBITS:1]) begin
                        cpu_rdy_n  = 1'b1;
                        cpu_dout_n = sdr_dout;
                    end
                    if (fill_cnt == LAST_IDX) begin
                        fill_cnt_n  = '0;
                        c_tag_we    = 1'b1;
                        c_set_valid = !(fill_flushed || flush);
                        state_n     = SDR_IDLE;
                    end else begin
                        fill_cnt_n = fill_cnt + 1'b1;
                    end
                end
            end
            SDR_WR_REQ: begin
                if (sdr_ack) begin
                    sdr_req_n = 1'b0;
                    sdr_wr_n  = 1'b0;
                    cpu_rdy_n = 1'b1;
                    c_wr_we   = c_hit;
                    state_n   = SDR_IDLE;
                end
            end
            default: begin
                state_n = SDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SDR_IDLE;
            cpu_rdy      <= 1'b0;
            cpu_dout     <= '0;
            sdr_addr     <= '0;
            sdr_wr       <= 1'b0;
            sdr_be       <= '0;
            sdr_din      <= '0;
            sdr_req      <= 1'b0;
            cur_addr     <= '0;
            cur_din      <= '0;
            cur_sel      <= '0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_din     <= '0;
            pend_sel     <= '0;
            fill_cnt     <= '0;
            fill_flushed <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            state        <= state_n;
            cpu_rdy      <= cpu_rdy_n;
            cpu_dout     <= cpu_dout_n;
            sdr_addr     <= sdr_addr_n;
            sdr_wr       <= sdr_wr_n;
            sdr_be       <= sdr_be_n;
            sdr_din      <= sdr_din_n;
            sdr_req      <= sdr_req_n;
            cur_addr     <= cur_addr_n;
            cur_din      <= cur_din_n;
            cur_sel      <= cur_sel_n;
            pend_valid   <= pend_valid_n;
            pend_addr    <= pend_addr_n;
            pend_din     <= pend_din_n;
            pend_sel     <= pend_sel_n;
            fill_cnt     <= fill_cnt_n;
            fill_flushed <= fill_flushed_n;
            ovf_err      <= ovf_err_n;
        end
    end

endmodule

// File: tb/tb_m92_sdr_cpu_port.sv
// tb/tb_m92_sdr_cpu_port.sv - directed self-checking bench for m92_sdr_cpu_port
module tb_m92_sdr_cpu_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_wr_sel;
    logic        cpu_req;
    logic [15:0] cpu_dout;
    logic        cpu_rdy;
    logic        flush;
    logic [24:0] sdr_addr;
    logic        sdr_wr;
    logic [1:0]  sdr_be;
    logic [15:0] sdr_din;
    logic        sdr_req;
    logic        sdr_ack;
    logic [15:0] sdr_dout;
    logic        sdr_dout_valid;

    int total = 0;
    int bad   = 0;
    int rdy_cnt = 0;
    int r0;

    always #5 clk = ~clk;

    m92_sdr_cpu_port dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_wr_sel     (cpu_wr_sel),
        .cpu_req        (cpu_req),
        .cpu_dout       (cpu_dout),
        .cpu_rdy        (cpu_rdy),
        .flush          (flush),
        .sdr_addr       (sdr_addr),
        .sdr_wr         (sdr_wr),
        .sdr_be         (sdr_be),
        .sdr_din        (sdr_din),
        .sdr_req        (sdr_req),
        .sdr_ack        (sdr_ack),
        .sdr_dout       (sdr_dout),
        .sdr_dout_valid (sdr_dout_valid)
    );

    always @(negedge clk) begin
        if (cpu_rdy) rdy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_pulse(input logic [24:0] a, input logic [15:0] d, input logic [1:0] sel);
        cpu_addr   = a;
        cpu_din    = d;
        cpu_wr_sel = sel;
        cpu_req    = 1'b1;
        tick();
        cpu_req    = 1'b0;
    endtask

    task automatic ack_read(input string tag);
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        check({tag, "_req_drop"}, 32'(sdr_req), 32'd0);
    endtask

    // Word i of the burst is words[16*i +: 16]; crit = expected rdy word index.
    task automatic fill(input string tag, input logic [63:0] words, input int crit, input int flush_at);
        for (int i = 0; i < 4; i++) begin
            sdr_dout       = words[16*i +: 16];
            sdr_dout_valid = 1'b1;
            flush          = (i == flush_at);
            tick();
            check($sformatf("%s_rdy%0d", tag, i), 32'(cpu_rdy), 32'(i == crit));
            if (i == crit) check({tag, "_dout"}, 32'(cpu_dout), 32'(words[16*i +: 16]));
            check($sformatf("%s_noreq%0d", tag, i), 32'(sdr_req), 32'd0);
        end
        sdr_dout_valid = 1'b0;
        flush          = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_wr_sel = '0; cpu_req = 1'b0;
        flush = 1'b0; sdr_ack = 1'b0; sdr_dout = '0; sdr_dout_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_rdy",  32'(cpu_rdy),  32'd0);
        check("rst_dout", 32'(cpu_dout), 32'd0);
        check("rst_req",  32'(sdr_req),  32'd0);
        check("rst_sdr",  {sdr_wr, sdr_be, sdr_addr}, 32'd0);
        check("rst_din",  32'(sdr_din),  32'd0);

        // Cold read, critical word is the third one
        cpu_pulse(25'h000104, 16'h0, 2'b00);
        check("t1_req",  32'(sdr_req),  32'd1);
        check("t1_addr", 32'(sdr_addr), 32'h100);
        check("t1_wr",   32'(sdr_wr),   32'd0);
        tick();
        check("t1_req_hold", 32'(sdr_req), 32'd1);
        ack_read("t1");
        fill("t1", {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 2, -1);
        check("t1_valid", 32'(dut.u_cache.valid), 32'd1);

        // Hit on the filled line
        cpu_pulse(25'h000102, 16'h0, 2'b00);
        check("t2_rdy",   32'(cpu_rdy),  32'd1);
        check("t2_dout",  32'(cpu_dout), 32'h2222);
        check("t2_noreq", 32'(sdr_req),  32'd0);
        tick();
        check("t2_rdy_pulse", 32'(cpu_rdy), 32'd0);

        // Write hit with upper byte enable
        cpu_pulse(25'h000102, 16'hABCD, 2'b10);
        check("t3_req",  32'(sdr_req),  32'd1);
        check("t3_wr",   32'(sdr_wr),   32'd1);
        check("t3_be",   32'(sdr_be),   32'd2);
        check("t3_din",  32'(sdr_din),  32'hABCD);
        check("t3_addr", 32'(sdr_addr), 32'h102);
        tick();
        check("t3_hold", 32'(sdr_req), 32'd1);
        check("t3_early_rdy", 32'(cpu_rdy), 32'd0);
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        check("t3_rdy",  32'(cpu_rdy), 32'd1);
        check("t3_drop", 32'(sdr_req), 32'd0);
        tick();
        cpu_pulse(25'h000102, 16'h0, 2'b00);
        check("t3_rerd_rdy",  32'(cpu_rdy),  32'd1);
        check("t3_rerd_dout", 32'(cpu_dout), 32'hAB22);
        tick();

        // Write miss leaves the line alone
        cpu_pulse(25'h000200, 16'h5555, 2'b11);
        check("t4_addr", 32'(sdr_addr), 32'h200);
        check("t4_be",   32'(sdr_be),   32'd3);
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        check("t4_rdy", 32'(cpu_rdy), 32'd1);
        tick();
        cpu_pulse(25'h000100, 16'h0, 2'b00);
        check("t4_hit_rdy",  32'(cpu_rdy),  32'd1);
        check("t4_hit_dout", 32'(cpu_dout), 32'h1111);
        check("t4_noreq",    32'(sdr_req),  32'd0);
        tick();

        // Read miss, write parked behind it, third pulse dropped
        r0 = rdy_cnt;
        cpu_pulse(25'h000300, 16'h0, 2'b00);
        check("t5_raddr", 32'(sdr_addr), 32'h300);
        tick();
        cpu_pulse(25'h000104, 16'h00EE, 2'b01);
        check("t5_ovf0", 32'(dut.ovf_err), 32'd0);
        check("t5_rd_req", {sdr_req, sdr_wr}, 32'b10);
        ack_read("t5");
        cpu_pulse(25'h000100, 16'h0, 2'b00);
        check("t5_ovf1", 32'(dut.ovf_err), 32'd1);
        fill("t5", {16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0}, 0, -1);
        tick();
        check("t5_wreq",  {sdr_req, sdr_wr}, 32'b11);
        check("t5_waddr", 32'(sdr_addr), 32'h104);
        check("t5_wbe",   32'(sdr_be),   32'd1);
        check("t5_wdin",  32'(sdr_din),  32'h00EE);
        sdr_ack = 1'b1;
        tick();
        sdr_ack = 1'b0;
        check("t5_wrdy", 32'(cpu_rdy), 32'd1);
        repeat (4) tick();
        check("t5_rdy_count", 32'(rdy_cnt - r0), 32'd2);
        check("t5_idle", 32'(sdr_req), 32'd0);

        // Flush together with a hit forces a miss
        flush = 1'b1;
        cpu_pulse(25'h000302, 16'h0, 2'b00);
        flush = 1'b0;
        check("t6a_req",  32'(sdr_req),  32'd1);
        check("t6a_addr", 32'(sdr_addr), 32'h300);
        check("t6a_rdy",  32'(cpu_rdy),  32'd0);
        ack_read("t6a");
        fill("t6a", {16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0}, 1, -1);
        check("t6a_valid", 32'(dut.u_cache.valid), 32'd1);

        // Flush during the fill: answered, line left invalid
        cpu_pulse(25'h000106, 16'h0, 2'b00);
        check("t6b_addr", 32'(sdr_addr), 32'h100);
        ack_read("t6b");
        fill("t6b", {16'hB3B3, 16'hB2B2, 16'hB1B1, 16'hB0B0}, 3, 1);
        check("t6b_valid", 32'(dut.u_cache.valid), 32'd0);
        tick();
        cpu_pulse(25'h000106, 16'h0, 2'b00);
        check("t6c_req",  32'(sdr_req),  32'd1);
        check("t6c_addr", 32'(sdr_addr), 32'h100);
        ack_read("t6c");

        // Reset mid-fill, coinciding with the critical word
        for (int i = 0; i < 3; i++) begin
            sdr_dout       = 16'hD0D0 + 16'(i);
            sdr_dout_valid = 1'b1;
            tick();
            check($sformatf("t6c_rdy%0d", i), 32'(cpu_rdy), 32'd0);
        end
        sdr_dout = 16'hD3D3;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check("t6c_rst_rdy",  32'(cpu_rdy),  32'd0);
        check("t6c_rst_req",  32'(sdr_req),  32'd0);
        check("t6c_rst_dout", 32'(cpu_dout), 32'd0);
        sdr_dout = 16'hEEEE;
        tick();
        sdr_dout_valid = 1'b0;
        check("t6c_stray_rdy", 32'(cpu_rdy), 32'd0);
        check("t6c_valid",     32'(dut.u_cache.valid), 32'd0);
        tick();
        cpu_pulse(25'h000106, 16'h0, 2'b00);
        check("t6c_remiss", 32'(sdr_req), 32'd1);
        check("t6c_ovf_clr", 32'(dut.ovf_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m92_sdr_cpu_port.md
Name: m92_sdr_cpu_port

Overview:
- SDRAM-side responder for the main-CPU SDRAM channel driven by the M92 top level (sdr_cpu_addr/din/wr_sel/req, returns rdy/dout).
- Runs in the 96 MHz SDRAM domain. Accepts single-cycle request pulses, performs word reads/writes against the SDRAM controller, and returns a single-cycle ready pulse with data.
- A one-line read cache (LINE_WORDS x 16 bit) cuts ROM fetch latency. Writes go through to SDRAM and keep the cache coherent.

Parameters:
- LINE_WORDS, 4: words per cache line and per SDRAM read burst; power of two, 2..8.
- CACHE_EN, 1: 0 forces every read to miss (line still filled, never hit).

Ports:
- clk  in  1  96 MHz SDRAM clock.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  25  byte address; bit 0 ignored.
- cpu_din  in  16  write data.
- cpu_wr_sel  in  2  byte enables; 00 = read.
- cpu_req  in  1  single-cycle request pulse; addr/din/wr_sel valid this cycle.
- cpu_dout  out  16  read data; valid on cpu_rdy, held until the next cpu_rdy.
- cpu_rdy  out  1  single-cycle completion pulse, for reads and writes.
- flush  in  1  invalidates the cache line.
- sdr_addr  out  25  word-aligned; line-aligned for reads.
- sdr_wr  out  1  1 = write, 0 = burst read.
- sdr_be  out  2  write byte enables.
- sdr_din  out  16  write data.
- sdr_req  out  1  level; held until sdr_ack.
- sdr_ack  in  1  single-cycle: command accepted (read) / write complete.
- sdr_dout  in  16  burst read word.
- sdr_dout_valid  in  1  one pulse per burst word, in order word 0..LINE_WORDS-1.

Behaviour:
- Reset values:
  - cpu_rdy=0, cpu_dout=0, sdr_req=0, sdr_wr=0, sdr_be=0, sdr_addr=0, sdr_din=0.
  - Line invalid, state IDLE, pending slot empty.
- Request capture: on cpu_req, addr/din/wr_sel are registered.
- Busy handling:
  - If busy, the request goes into a single pending slot and is served immediately after the current one completes.
  - If cpu_req arrives while the pending slot is already full, it is dropped and the sticky internal flag ovf_err is set (for verification visibility only).
- Line geometry: tag = addr[24:log2(LINE_WORDS)+1], word index = addr[log2(LINE_WORDS):1].
- States: IDLE, HIT, RD_REQ, RD_FILL, WR_REQ.
- IDLE, read, cache hit (valid & tag match & CACHE_EN):
  - go to HIT; next cycle cpu_rdy=1 with the cached word.
  - Latency is req at cycle N -> rdy at N+1.
  - Return to IDLE.
- IDLE, read, miss:
  - RD_REQ: sdr_req=1, sdr_wr=0, sdr_addr = line base, from N+1 until sdr_ack.
  - Line valid cleared at miss start.
- RD_FILL:
  - Each sdr_dout_valid writes the next word and increments the fill counter (wraps at LINE_WORDS).
  - Critical word: cpu_rdy pulses in the cycle after the requested word arrives; cpu_dout = that word.
  - After the last word: tag stored, valid=1, go to IDLE.
  - A new/pending request is not started before the fill completes.
- IDLE, write (wr_sel != 00):
  - WR_REQ: sdr_req=1, sdr_wr=1, sdr_be=wr_sel, sdr_din=cpu_din, sdr_addr = word address.
  - On sdr_ack: cpu_rdy pulses the next cycle.
  - If the tag hits, the cached word is byte-merged at the same cycle.
  - Go to IDLE.
- flush:
  - Clears valid in any state.
  - Flush during RD_FILL: the fill completes and the CPU is answered, but the line stays invalid.
  - Flush and a hit arriving in the same cycle: flush wins, so the request is treated as a miss.
- Reset mid-operation: immediate return to reset values. Any in-flight SDRAM burst words arriving after reset are ignored (fill counter idle).
- sdr_req is never dropped before sdr_ack. sdr_ack outside RD_REQ/WR_REQ is ignored.

Decomposition:
- m92_pkg gets:
  - sdr_cpu_state_t (enum of the five states);
  - constant SDR_CPU_LINE_WORDS=4;
  - function line_tag(addr).
- Sub-module m92_line_cache holds the data array plus tag/valid. It provides:
  - a byte-enable write port;
  - a fill write port;
  - a combinational hit/read port.
- The FSM and pending slot stay in the top.

Test Plan:
- Cold read at 0x000104: sdr_req with sdr_addr=0x000100 (line base). Return burst 0x1111,0x2222,0x3333,0x4444 -> cpu_rdy one cycle after the third word, cpu_dout=0x3333; valid set after the fourth word.
- Read at 0x000102 right after the fill -> cpu_rdy at N+1 with 0x2222, no sdr_req.
- Write 0xABCD, wr_sel=10, to 0x000102 (hit) -> sdr_wr=1, sdr_be=10; rdy after ack. Re-read returns 0xAB22.
- Write to 0x000200 (miss) -> line unchanged; a following read of 0x000100 still hits.
- Read and then write pulsed 2 cycles apart while the first misses -> the write is issued only after the fill completes, each gets exactly one cpu_rdy, ovf_err=0. A third pulse while pending is full -> dropped, ovf_err=1.
- Flush during RD_FILL -> the CPU is still answered, and the next read of the same line issues a new burst. Reset asserted while in RD_FILL -> cpu_rdy stays 0 and sdr_req=0 next cycle.
